// File: rtl/rv32i_types.sv
// Shared RV32 types for the execute-stage multiply/divide resource.
package rv32i_types;

    typedef enum logic [2:0] {
        MUL    = 3'b000,
        MULH   = 3'b001,
        MULHSU = 3'b010,
        MULHU  = 3'b011,
        DIV    = 3'b100,
        DIVU   = 3'b101,
        REM    = 3'b110,
        REMU   = 3'b111
    } muldiv_funct3_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } muldiv_state_t;

    localparam int unsigned MULDIV_CNT_W = $clog2(32) + 1;

endpackage

// File: rtl/muldiv_iter_dp.sv
// Radix-2 iterative datapath: shift-add multiply or restoring shift-subtract divide.
// acc holds {hi, lo}: product halves when multiplying, {remainder, quotient} when dividing.
module muldiv_iter_dp #(
    parameter int unsigned XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init,
    input  logic              step,
    input  logic              is_div,
    input  logic [XLEN-1:0]   a_mag,
    input  logic [XLEN-1:0]   b_mag,
    output logic [2*XLEN-1:0] acc_nxt
);
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   opnd;
    logic [XLEN:0]     sum;
    logic [XLEN:0]     trial;
    logic [XLEN+1:0]   diff;
    logic [2*XLEN-1:0] mul_nxt;
    logic [2*XLEN-1:0] div_nxt;

    always_comb begin
        sum     = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_nxt = {sum, acc[XLEN-1:1]};

        // Partial remainder can reach XLEN+1 bits after the shift-in.
        trial = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        diff  = {1'b0, trial} - {2'b00, opnd};
        if (!diff[XLEN+1])
            div_nxt = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        else
            div_nxt = {trial[XLEN-1:0], acc[XLEN-2:0], 1'b0};

        acc_nxt = is_div ? div_nxt : mul_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc  <= '0;
            opnd <= '0;
        end else if (init) begin
            acc  <= {{XLEN{1'b0}}, a_mag};
            opnd <= b_mag;
        end else if (step) begin
            acc  <= acc_nxt;
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M multiply/divide sequencer: FSM, counter, sign fix-up and result register.
// Optional MULDIV_EARLY_OUT_EN: zero-operand multiply, divide-by-zero and overflow finish from IDLE.
module muldiv_seq
    import rv32i_types::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  muldiv_funct3_t  funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    input  logic            mem_stall,
    output logic [XLEN-1:0] f,
    output logic            resp,
    output logic            busy
);
    localparam int unsigned     CNT_W   = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_t     state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    muldiv_funct3_t    op;
    logic              neg_res, neg_rem, div_zero, div_ovf;
    logic [XLEN-1:0]   a_raw;

    logic              a_neg, b_neg, accept, step_en, last_step, is_div;
    logic              in_div_zero, in_div_ovf;
    logic [XLEN-1:0]   a_mag, b_mag, quot, rem, res_calc;
    logic [2*XLEN-1:0] acc_nxt, prod;

    always_comb begin
        a_neg       = (funct3 inside {MULH, MULHSU, DIV, REM}) && a[XLEN-1];
        b_neg       = (funct3 inside {MULH, DIV, REM}) && b[XLEN-1];
        a_mag       = a_neg ? '0 - a : a;
        b_mag       = b_neg ? '0 - b : b;
        in_div_zero = (funct3 inside {DIV, DIVU, REM, REMU}) && (b == '0);
        in_div_ovf  = (funct3 inside {DIV, REM}) && (a == INT_MIN) && (b == '1);
        accept      = (state == IDLE) && start && !flush;
        step_en     = (state == CALC) && !flush;
        last_step   = (state == CALC) && (cnt == CNT_W'(1));
        is_div      = op inside {DIV, DIVU, REM, REMU};
    end

`ifdef MULDIV_EARLY_OUT_EN
    logic            early_hit;
    logic [XLEN-1:0] early_res;

    always_comb begin
        early_res = '0;
        early_hit = in_div_zero || in_div_ovf ||
                    ((funct3 inside {MUL, MULH, MULHSU, MULHU}) && (a == '0 || b == '0));
        if (in_div_zero)
            early_res = (funct3 inside {REM, REMU}) ? a : '1;
        else if (in_div_ovf)
            early_res = (funct3 == REM) ? '0 : INT_MIN;
    end
`endif

    muldiv_iter_dp #(.XLEN(XLEN)) u_dp (
        .clk     (clk),
        .rst     (rst),
        .init    (accept),
        .step    (step_en),
        .is_div  (is_div),
        .a_mag   (a_mag),
        .b_mag   (b_mag),
        .acc_nxt (acc_nxt)
    );

    // Result is taken from the final step's combinational output so it lands on DONE entry.
    always_comb begin
        prod = neg_res ? '0 - acc_nxt : acc_nxt;
        quot = acc_nxt[XLEN-1:0];
        rem  = acc_nxt[2*XLEN-1:XLEN];
        case (op)
            MUL:                 res_calc = prod[XLEN-1:0];
            MULH, MULHSU, MULHU: res_calc = prod[2*XLEN-1:XLEN];
            DIV, DIVU:           res_calc = div_zero ? '1 :
                                            div_ovf  ? INT_MIN :
                                            neg_res  ? '0 - quot : quot;
            default:             res_calc = div_zero ? a_raw :
                                            div_ovf  ? '0 :
                                            neg_rem  ? '0 - rem : rem;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
`ifdef MULDIV_EARLY_OUT_EN
                    state_nxt = early_hit ? DONE : CALC;
`else
                    state_nxt = CALC;
`endif
                end
            end
            CALC: begin
                if (flush)
                    state_nxt = IDLE;
                else if (cnt == CNT_W'(1))
                    state_nxt = DONE;
            end
            DONE: begin
                if (flush || !mem_stall)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            f        <= '0;
            op       <= MUL;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            div_ovf  <= 1'b0;
            a_raw    <= '0;
        end else if (accept) begin
            op       <= funct3;
            neg_res  <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            div_zero <= in_div_zero;
            div_ovf  <= in_div_ovf;
            a_raw    <= a;
            cnt      <= CNT_W'(XLEN);
`ifdef MULDIV_EARLY_OUT_EN
            if (early_hit)
                f <= early_res;
`endif
        end else if (step_en) begin
            cnt <= cnt - CNT_W'(1);
            if (last_step)
                f <= res_calc;
        end
    end

    assign resp = (state == DONE);
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: arithmetic reference model plus directed vectors.
module tb_muldiv_seq;
    import rv32i_types::*;

    localparam int unsigned XLEN = 32;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    logic           clk = 1'b0;
    logic           rst, start, flush, mem_stall;
    muldiv_funct3_t funct3;
    logic [31:0]    a, b, f;
    logic           resp, busy;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_f = '0;
    logic [31:0] last_f = '0;

    muldiv_seq #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .funct3    (funct3),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .mem_stall (mem_stall),
        .f         (f),
        .resp      (resp),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, got, want, $time);
        end
    endtask

    function automatic logic [31:0] model(input muldiv_funct3_t op, input logic [31:0] x, input logic [31:0] y);
        longint          sx, sy;
        longint unsigned ux, uy;
        logic [63:0]     p;
        sx = $signed(x);
        sy = $signed(y);
        ux = {32'b0, x};
        uy = {32'b0, y};
        case (op)
            MUL:    begin p = ux * uy; return p[31:0];  end
            MULH:   begin p = sx * sy; return p[63:32]; end
            MULHSU: begin p = sx * uy; return p[63:32]; end
            MULHU:  begin p = ux * uy; return p[63:32]; end
            DIV: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (x == INT_MIN && y == 32'hFFFF_FFFF) return INT_MIN;
                p = sx / sy; return p[31:0];
            end
            DIVU: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            REM: begin
                if (y == 0) return x;
                if (x == INT_MIN && y == 32'hFFFF_FFFF) return 32'h0;
                p = sx % sy; return p[31:0];
            end
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic int latency(input muldiv_funct3_t op, input logic [31:0] x, input logic [31:0] y);
`ifdef MULDIV_EARLY_OUT_EN
        bit is_div;
        is_div = op inside {DIV, DIVU, REM, REMU};
        if (is_div && y == 0) return 1;
        if ((op == DIV || op == REM) && x == INT_MIN && y == 32'hFFFF_FFFF) return 1;
        if (!is_div && (x == 0 || y == 0)) return 1;
`endif
        return XLEN + 1;
    endfunction

    // Result must match the model on every cycle resp is high.
    always @(negedge clk) begin
        if (!rst && resp)
            check("f_model", f, exp_f);
    end

    // Called at a negedge with the DUT idle; returns at the negedge of the first idle cycle.
    task automatic run_op(input muldiv_funct3_t op, input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] hand, input int stall);
        int lat;
        lat   = latency(op, av, bv);
        exp_f = model(op, av, bv);
        check("model_pin", exp_f, hand);
        funct3 = op; a = av; b = bv; start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        a      = $urandom;
        b      = $urandom;
        funct3 = muldiv_funct3_t'(3'($urandom));
        for (int k = 1; k <= lat; k++) begin
            if (k > 1) @(negedge clk);
            check("busy", 32'(busy), 32'd1);
            check("resp", 32'(resp), 32'(k == lat));
            mem_stall = (stall > 0) && ((k >= 5 && k <= 8) || k == lat);
        end
        check("f_hand", f, hand);
        for (int s = 1; s <= stall; s++) begin
            @(negedge clk);
            check("stall_resp", 32'(resp), 32'd1);
            check("stall_f", f, hand);
        end
        mem_stall = 1'b0;
        @(negedge clk);
        check("idle_resp", 32'(resp), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        last_f = hand;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; funct3 = MUL; a = '0; b = '0; flush = 1'b0; mem_stall = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_f", f, 32'd0);
        check("rst_resp", 32'(resp), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);
        run_op(MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 0);
        run_op(MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
        run_op(MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(MULH,   32'hFFFF_FFFE,  32'd3,         32'hFFFF_FFFF, 0);
        run_op(MUL,    32'd0,          32'h1234_5678, 32'd0,         0);
        run_op(DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 0);
        run_op(REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 0);
        run_op(DIVU,   32'd100,        32'd7,         32'd14,        0);
        run_op(REMU,   32'd100,        32'd7,         32'd2,         0);
        run_op(DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 0);
        run_op(REMU,   32'd5,          32'd0,         32'd5,         0);
        run_op(DIV,    32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFF, 0);
        run_op(REM,    32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFB, 0);
        run_op(DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 0);
        run_op(REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         0);
        run_op(DIVU,   32'd100,        32'd7,         32'd14,        3);
        run_op(MUL,    32'd3,          32'd4,         32'd12,        0);

        // Flush in cycle 10 of CALC: aborts, result never appears, f keeps its old value.
        funct3 = MUL; a = 32'd3; b = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            if (k > 1) @(negedge clk);
            check("flush_busy_pre", 32'(busy), 32'd1);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_resp", 32'(resp), 32'd0);
        check("flush_f", f, last_f);
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            check("flush_no_resp", 32'(resp), 32'd0);
        end

        // Reset in cycle 20 of CALC discards the operation.
        funct3 = DIVU; a = 32'd100; b = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 2; k <= 20; k++) @(negedge clk);
        check("rstmid_busy_pre", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstmid_f", f, 32'd0);
        check("rstmid_resp", 32'(resp), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);

        run_op(REMU, 32'd100, 32'd7, 32'd2, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
